// File: rtl/mem_iface.sv
// Memory-side bus endpoint for the LC-3b datapath: MAR/MDR registers and a
// single-port req/ack memory sequencer with alignment and timeout checks.
module mem_iface #(
  parameter int MEM_TIMEOUT = 15
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] bus_in,
  input  logic        ld_mar,
  input  logic        ld_mdr,
  input  logic        data_size,
  input  logic        r_w,
  input  logic        mem_start,
  input  logic        gate_mdr,
  output logic [15:0] bus_out,
  output logic        ready,
  output logic        busy,
  output logic        err,
  output logic        mem_req,
  output logic        mem_we,
  output logic [14:0] mem_addr,
  output logic [1:0]  mem_be,
  output logic [15:0] mem_wdata,
  input  logic [15:0] mem_rdata,
  input  logic        mem_ack
);

  typedef enum logic [1:0] {IDLE, WAIT, DONE} state_t;

  localparam logic [7:0] TO_LAST = 8'(MEM_TIMEOUT - 1);

  state_t      state, state_nxt;
  logic [15:0] mar, mdr;
  logic [7:0]  cnt;
  logic        r_w_q, size_q, err_q;
  logic        start_ok, start_bad, timeout;

  function automatic logic signed [15:0] sext_byte(input logic [7:0] b);
    return {{8{b[7]}}, b};
  endfunction

  assign start_bad = (state == IDLE) && mem_start && data_size && mar[0];
  assign start_ok  = (state == IDLE) && mem_start && !(data_size && mar[0]);
  // ack on the final WAIT cycle wins over the timeout
  assign timeout   = (state == WAIT) && !mem_ack && (cnt == TO_LAST);

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start_bad) state_nxt = DONE;
               else if (start_ok) state_nxt = WAIT;
      WAIT:    if (mem_ack || timeout) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mar    <= '0;
      mdr    <= '0;
      cnt    <= '0;
      r_w_q  <= 1'b0;
      size_q <= 1'b0;
      err_q  <= 1'b0;
    end else begin
      if (state == IDLE) begin
        if (ld_mar) mar <= bus_in;
        if (ld_mdr) mdr <= data_size ? bus_in : {bus_in[7:0], bus_in[7:0]};
      end
      if (start_ok) begin
        r_w_q  <= r_w;
        size_q <= data_size;
        cnt    <= '0;
        err_q  <= 1'b0;
      end
      if (start_bad) err_q <= 1'b1;
      if (state == WAIT) begin
        cnt <= cnt + 8'd1;
        if (mem_ack && !r_w_q) mdr <= mem_rdata;
        if (timeout) err_q <= 1'b1;
      end
    end
  end

  assign mem_req   = (state == WAIT);
  assign mem_we    = mem_req && r_w_q;
  assign mem_addr  = mar[15:1];
  assign mem_wdata = mdr;
  assign ready     = (state == DONE);
  assign busy      = (state != IDLE);
  assign err       = err_q;

  always_comb begin
    mem_be = 2'b00;
    if (mem_req) mem_be = size_q ? 2'b11 : (mar[0] ? 2'b10 : 2'b01);
  end

  always_comb begin
    bus_out = 16'h0000;
    if (gate_mdr) begin
      if (data_size) bus_out = mdr;
      else           bus_out = sext_byte(mar[0] ? mdr[15:8] : mdr[7:0]);
    end
  end

endmodule

// File: tb/tb_mem_iface.sv
// Directed bench for mem_iface: expected memory requests are queued when an
// access is launched and compared when the DUT raises mem_req.
module tb_mem_iface;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] bus_in;
  logic        ld_mar, ld_mdr, data_size, r_w, mem_start, gate_mdr;
  logic [15:0] bus_out;
  logic        ready, busy, err, mem_req, mem_we;
  logic [14:0] mem_addr;
  logic [1:0]  mem_be;
  logic [15:0] mem_wdata, mem_rdata;
  logic        mem_ack;

  int n_vec = 0;
  int n_bad = 0;

  typedef struct packed {
    logic [14:0] addr;
    logic [1:0]  be;
    logic        we;
    logic [15:0] wdata;
  } req_t;

  req_t sb_q[$];

  mem_iface #(.MEM_TIMEOUT(4)) dut (
    .clk(clk), .rst(rst), .bus_in(bus_in), .ld_mar(ld_mar), .ld_mdr(ld_mdr),
    .data_size(data_size), .r_w(r_w), .mem_start(mem_start), .gate_mdr(gate_mdr),
    .bus_out(bus_out), .ready(ready), .busy(busy), .err(err), .mem_req(mem_req),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_be(mem_be), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ack(mem_ack)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load_mar(input logic [15:0] v);
    bus_in = v; ld_mar = 1'b1;
    tick();
    ld_mar = 1'b0;
  endtask

  task automatic load_mdr(input logic [15:0] v, input logic sz);
    bus_in = v; data_size = sz; ld_mdr = 1'b1;
    tick();
    ld_mdr = 1'b0;
  endtask

  task automatic expect_req(input logic [14:0] a, input logic [1:0] be,
                            input logic we, input logic [15:0] wd);
    req_t e;
    e.addr = a; e.be = be; e.we = we; e.wdata = wd;
    sb_q.push_back(e);
  endtask

  task automatic compare_req();
    req_t e;
    chk("sb_pending", 32'(sb_q.size() > 0), 32'd1);
    if (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      chk("mem_addr",  32'(mem_addr),  32'(e.addr));
      chk("mem_be",    32'(mem_be),    32'(e.be));
      chk("mem_we",    32'(mem_we),    32'(e.we));
      chk("mem_wdata", 32'(mem_wdata), 32'(e.wdata));
    end
  endtask

  task automatic gate_check(input string tag, input logic sz, input logic [15:0] exp);
    gate_mdr = 1'b1; data_size = sz;
    #1;
    chk(tag, 32'(bus_out), 32'(exp));
    gate_mdr = 1'b0;
    #1;
    chk("bus_out_ungated", 32'(bus_out), 32'h0);
  endtask

  // ack_at < 0 means mem_ack is never driven
  task automatic do_access(input logic rw, input logic sz, input int ack_at,
                           input logic [15:0] rdata, input logic exp_err,
                           input int exp_wait);
    int waits;
    int budget;
    waits = 0;
    budget = 0;
    r_w = rw; data_size = sz; mem_start = 1'b1;
    tick();
    mem_start = 1'b0;
    while (!ready && budget < 40) begin
      if (mem_req) begin
        if (waits == 0) compare_req();
        if (waits == ack_at) begin
          mem_ack = 1'b1;
          mem_rdata = rdata;
        end
        waits++;
      end
      tick();
      mem_ack = 1'b0;
      budget++;
    end
    chk("ready_seen",   32'(ready), 32'd1);
    chk("wait_cycles",  32'(waits), 32'(exp_wait));
    chk("busy_in_done", 32'(busy), 32'd1);
    chk("req_in_done",  32'(mem_req), 32'd0);
    chk("be_no_req",    32'(mem_be), 32'd0);
    chk("err_at_ready", 32'(err), 32'(exp_err));
    tick();
    chk("ready_pulse",  32'(ready), 32'd0);
    chk("busy_idle",    32'(busy), 32'd0);
  endtask

  initial begin
    rst = 1'b1;
    bus_in = '0; ld_mar = 0; ld_mdr = 0; data_size = 0; r_w = 0;
    mem_start = 0; gate_mdr = 0; mem_rdata = '0; mem_ack = 0;
    #1;
    chk("rst_req",   32'(mem_req), 32'd0);
    chk("rst_ready", 32'(ready), 32'd0);
    chk("rst_busy",  32'(busy), 32'd0);
    chk("rst_err",   32'(err), 32'd0);
    chk("rst_addr",  32'(mem_addr), 32'd0);
    chk("rst_wdata", 32'(mem_wdata), 32'd0);
    tick();
    tick();
    rst = 1'b0;
    tick();

    // word write then word read back
    load_mar(16'h3000);
    load_mdr(16'hBEAD, 1'b1);
    expect_req(15'h1800, 2'b11, 1'b1, 16'hBEAD);
    do_access(1'b1, 1'b1, 1, 16'h0000, 1'b0, 2);
    load_mdr(16'h0000, 1'b1);
    expect_req(15'h1800, 2'b11, 1'b0, 16'h0000);
    do_access(1'b0, 1'b1, 0, 16'hBEAD, 1'b0, 1);
    gate_check("word_read_bus", 1'b1, 16'hBEAD);

    // byte write at odd address
    load_mar(16'h3001);
    load_mdr(16'h12F0, 1'b0);
    gate_check("byte_ld_mdr", 1'b1, 16'hF0F0);
    expect_req(15'h1800, 2'b10, 1'b1, 16'hF0F0);
    do_access(1'b1, 1'b0, 0, 16'h0000, 1'b0, 1);

    // byte read and sign extension on each lane
    expect_req(15'h1800, 2'b10, 1'b0, 16'hF0F0);
    do_access(1'b0, 1'b0, 2, 16'h8A7F, 1'b0, 3);
    gate_check("ldb_high", 1'b0, 16'hFF8A);
    load_mar(16'h3000);
    gate_check("ldb_low", 1'b0, 16'h007F);

    // unaligned word: no request, err, then cleared by an aligned start
    load_mar(16'h3003);
    do_access(1'b0, 1'b1, -1, 16'h0000, 1'b1, 0);
    chk("err_sticky", 32'(err), 32'd1);
    load_mar(16'h3000);
    expect_req(15'h1800, 2'b11, 1'b1, 16'h8A7F);
    do_access(1'b1, 1'b1, 0, 16'h0000, 1'b0, 1);

    // timeout: four WAIT cycles, MDR preserved
    expect_req(15'h1800, 2'b11, 1'b0, 16'h8A7F);
    do_access(1'b0, 1'b1, -1, 16'hDEAD, 1'b1, 4);
    gate_check("timeout_mdr", 1'b1, 16'h8A7F);

    // ld_mar and mem_start during WAIT are ignored
    expect_req(15'h1800, 2'b11, 1'b0, 16'h8A7F);
    r_w = 1'b0; data_size = 1'b1; mem_start = 1'b1;
    tick();
    mem_start = 1'b0;
    chk("rob_req", 32'(mem_req), 32'd1);
    compare_req();
    bus_in = 16'h4445; ld_mar = 1'b1; mem_start = 1'b1; r_w = 1'b1;
    tick();
    ld_mar = 1'b0; mem_start = 1'b0;
    chk("rob_addr", 32'(mem_addr), 32'h1800);
    chk("rob_we",   32'(mem_we), 32'd0);
    mem_ack = 1'b1; mem_rdata = 16'h1234;
    tick();
    mem_ack = 1'b0;
    chk("rob_ready", 32'(ready), 32'd1);
    tick();
    chk("rob_no_queue", 32'(busy), 32'd0);
    tick();
    chk("rob_no_queue2", 32'(mem_req), 32'd0);
    gate_check("rob_byte_lane", 1'b0, 16'h0034);

    // asynchronous reset while waiting
    expect_req(15'h1800, 2'b11, 1'b0, 16'h1234);
    r_w = 1'b0; data_size = 1'b1; mem_start = 1'b1;
    tick();
    mem_start = 1'b0;
    chk("rst_wait_req", 32'(mem_req), 32'd1);
    compare_req();
    #2 rst = 1'b1;
    #1;
    chk("arst_req",   32'(mem_req), 32'd0);
    chk("arst_busy",  32'(busy), 32'd0);
    chk("arst_ready", 32'(ready), 32'd0);
    @(posedge clk);
    #1 rst = 1'b0;
    mem_ack = 1'b1; mem_rdata = 16'h5555;
    tick();
    mem_ack = 1'b0;
    chk("late_ack_ready", 32'(ready), 32'd0);
    chk("late_ack_busy",  32'(busy), 32'd0);
    gate_check("late_ack_mdr", 1'b1, 16'h0000);

    chk("sb_drained", 32'(sb_q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/mem_iface.md
Name: mem_iface

Overview:
- Memory-side end of the LC-3b datapath bus. The ALU and other gated sources drive the bus; this block reads it into MAR/MDR.
- Runs single-port memory transactions with a req/ack handshake and drives MDR back onto the bus under gate_mdr.
- Supports LC-3b byte/word access and detects unaligned words and memory timeouts.

Parameters:
- MEM_TIMEOUT, 15: max cycles in WAIT without mem_ack before abort (1..255).

Ports:
- clk  input  1  system clock, rising-edge.
- rst  input  1  asynchronous, active-high reset.
- bus_in  input  16  current system bus value.
- ld_mar  input  1  load MAR from bus_in.
- ld_mdr  input  1  load MDR from bus_in.
- data_size  input  1  0 = byte, 1 = word.
- r_w  input  1  0 = read, 1 = write; sampled at mem_start.
- mem_start  input  1  single-cycle request to begin an access.
- gate_mdr  input  1  drive MDR view onto bus_out.
- bus_out  output  16  MDR view when gate_mdr, else 16'h0000.
- ready  output  1  one-cycle pulse when an access ends.
- busy  output  1  high in WAIT and DONE.
- err  output  1  sticky error flag.
- mem_req  output  1  memory request, held until ack or abort.
- mem_we  output  1  write strobe qualifier.
- mem_addr  output  15  word address = MAR[15:1].
- mem_be  output  2  byte enables, [1] = high byte.
- mem_wdata  output  16  write data = MDR.
- mem_rdata  input  16  read data, valid with mem_ack.
- mem_ack  input  1  memory completion, one cycle.

Behaviour:
- Reset (async, immediate):
  - MAR, MDR, counter = 0; state = IDLE.
  - All outputs 0, including mem_req/ready/err/busy.
  - Reset mid-access drops mem_req in the same instant.
- Registers:
  - MAR <= bus_in on ld_mar.
  - ld_mdr with data_size=1: MDR <= bus_in.
  - ld_mdr with data_size=0: MDR <= {bus_in[7:0], bus_in[7:0]} (byte replicated to both lanes).
  - ld_mar/ld_mdr are honoured only in IDLE and ignored while busy.
- bus_out (combinational):
  - gate_mdr=0: 16'h0000.
  - data_size=1: MDR.
  - data_size=0: sign-extended byte, MDR[15:8] if MAR[0]=1, else MDR[7:0].
- FSM states IDLE, WAIT, DONE:
  - IDLE, mem_start=1, alignment OK: latch r_w and data_size; mem_req=1 next cycle; go WAIT.
  - IDLE, mem_start=1, data_size=1 and MAR[0]=1: no request; err<=1; go DONE.
  - Any accepted mem_start first clears err. An unaligned start re-sets it in the same edge, so err ends at 1.
  - WAIT: mem_req=1; mem_we = latched r_w; mem_be = 2'b11 for word, 2'b10 if MAR[0]=1 byte, 2'b01 if MAR[0]=0 byte. mem_addr/mem_wdata come from MAR/MDR, which are frozen.
  - WAIT, mem_ack=1: mem_req<=0. On read, MDR <= mem_rdata (full word, both lanes). Go DONE.
  - WAIT, counter reaches MEM_TIMEOUT without ack: mem_req<=0; err<=1; MDR unchanged; go DONE. Counter clears on WAIT entry.
  - DONE: ready=1 for exactly one cycle; busy=1; next state IDLE.
  - mem_start outside IDLE is ignored and not queued.
  - mem_ack outside WAIT is ignored.
- Latency: start edge → mem_req the next cycle. Ack edge → ready the next cycle. Minimum start-to-ready is 3 cycles (ack on the first WAIT cycle).
- mem_we and mem_be are 0 whenever mem_req=0.

Test Plan:
- Word write/read: MAR=16'h3000, MDR=16'hBEAD, start write, ack after 2 cycles → mem_addr=15'h1800, be=2'b11, we=1, wdata=16'hBEAD, ready one pulse. Reload MDR=0, start read, mem_rdata=16'hBEAD → gate_mdr word gives bus_out=16'hBEAD.
- Byte write at odd address: MAR=16'h3001, byte ld_mdr bus_in=16'h12F0 → MDR=16'hF0F0; write issues be=2'b10, wdata=16'hF0F0.
- LDB sign extension: MAR=16'h3001, read returns 16'h8A7F → byte gate gives bus_out=16'hFF8A. With MAR=16'h3000 → 16'h007F.
- Unaligned word: MAR=16'h3003, word start → no mem_req ever, err=1, ready pulses 2 cycles after start. The next aligned start clears err.
- Timeout with MEM_TIMEOUT=4 and ack never asserted → mem_req drops after 4 WAIT cycles, err=1, ready pulses, MDR unchanged.
- Robustness: mem_start and ld_mar pulsed during WAIT → ignored, MAR unchanged. rst asserted in WAIT → mem_req, busy, ready = 0 immediately, state IDLE; a later ack is ignored.
